// File: rtl/sqrt_iter.sv
// Iterative restoring square root on DATA_WIDTH/FRACTION fixed point, one root bit per clock.
// Valid/ready streaming on both sides; one operand in flight at a time.
module sqrt_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRACTION   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  sqrt_ready_in,
  input  logic                  sqrt_valid_in,
  input  logic [DATA_WIDTH-1:0] sqrt_data_in,
  input  logic                  sqrt_ready_out,
  output logic                  sqrt_valid_out,
  output logic [DATA_WIDTH-1:0] sqrt_data_out,
  output logic                  sqrt_neg_out
);

  localparam int ITER      = (DATA_WIDTH + FRACTION + 1) / 2;
  localparam int RAD_WIDTH = 2 * ITER;
  localparam int REM_WIDTH = ITER + 2;
  localparam int CNT_WIDTH = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q;
  logic [RAD_WIDTH-1:0]  rad_q, rad_d, rad_load;
  logic [REM_WIDTH-1:0]  rem_q, rem_d, rem_shift, trial;
  logic [ITER-1:0]       root_q, root_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  neg_q, valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rad_load  = RAD_WIDTH'(sqrt_data_in) << FRACTION;
    rad_d     = rad_q << 2;
    rem_shift = {rem_q[REM_WIDTH-3:0], rad_q[RAD_WIDTH-1 -: 2]};
    trial     = {root_q, 2'b01};
    rem_d     = rem_shift;
    root_d    = root_q << 1;
    if (rem_shift >= trial) begin
      rem_d  = rem_shift - trial;
      root_d = (root_q << 1) | ITER'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sqrt_valid_in) begin
            rad_q   <= rad_load;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= CNT_WIDTH'(ITER);
            neg_q   <= sqrt_data_in[DATA_WIDTH-1];
            state_q <= CALC;
          end
        end
        CALC: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            data_q  <= neg_q ? '0 : DATA_WIDTH'(root_d);
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (sqrt_ready_out) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held low during reset so nothing is offered while the block is being cleared.
  assign sqrt_ready_in  = (state_q == IDLE) & ~rst;
  assign sqrt_valid_out = valid_q;
  assign sqrt_data_out  = data_q;
  assign sqrt_neg_out   = neg_q & valid_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter at default parameters: latency, boundaries, sign,
// backpressure, mid-operation reset and a short randomised run against a reference model.
module tb_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_in, valid_in, ready_out, valid_out, neg_out;
  logic [31:0] data_in, data_out;

  int tests = 0;
  int fails = 0;

  sqrt_iter dut (
    .clk            (clk),
    .rst            (rst),
    .sqrt_ready_in  (ready_in),
    .sqrt_valid_in  (valid_in),
    .sqrt_data_in   (data_in),
    .sqrt_ready_out (ready_out),
    .sqrt_valid_out (valid_out),
    .sqrt_data_out  (data_out),
    .sqrt_neg_out   (neg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Greedy bit search on y*y <= X*2^24 using a full multiply.
  function automatic logic [31:0] model(input logic [31:0] x);
    logic [63:0] n, y, t;
    if (x[31]) return 32'h0;
    n = {32'h0, x} << 24;
    y = 64'h0;
    for (int b = 27; b >= 0; b--) begin
      t = y | (64'h1 << b);
      if (t * t <= n) y = t;
    end
    return y[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Presents one operand, returns the result at the cycle valid rises.
  task automatic op(input logic [31:0] d, output logic [31:0] res, output logic neg,
                    output int lat);
    int k = 0;
    while (!ready_in && k < 200) begin
      tick();
      k++;
    end
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
    data_in  = $urandom;
    wait_valid(lat);
    res = data_out;
    neg = neg_out;
  endtask

  initial begin
    logic [31:0] res;
    logic        neg, ok;
    int          lat, gap;
    logic [31:0] x;

    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    repeat (3) tick();
    check("rst_valid", {63'h0, valid_out}, 64'h0);
    check("rst_data", {32'h0, data_out}, 64'h0);
    check("rst_neg", {63'h0, neg_out}, 64'h0);
    check("rst_ready_in", {63'h0, ready_in}, 64'h0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {63'h0, ready_in}, 64'h1);

    op(32'h04000000, res, neg, lat);
    check("sqrt4_data", {32'h0, res}, 64'h02000000);
    check("sqrt4_neg", {63'h0, neg}, 64'h0);
    check("sqrt4_latency", 64'(lat), 64'd28);
    tick();
    check("valid_drop", {63'h0, valid_out}, 64'h0);

    op(32'h01000000, res, neg, lat);
    check("sqrt1_data", {32'h0, res}, 64'h01000000);
    op(32'h02000000, res, neg, lat);
    check("sqrt2_data", {32'h0, res}, 64'h016A09E6);
    op(32'h00000000, res, neg, lat);
    check("zero_data", {32'h0, res}, 64'h0);
    op(32'h7FFFFFFF, res, neg, lat);
    check("max_data", {32'h0, res}, 64'h0B504F33);
    op(32'h00000001, res, neg, lat);
    check("lsb_data", {32'h0, res}, 64'h00001000);

    op(32'hFF000000, res, neg, lat);
    check("neg_data", {32'h0, res}, 64'h0);
    check("neg_flag", {63'h0, neg}, 64'h1);
    check("neg_latency", 64'(lat), 64'd28);

    // Backpressure with a second operand waiting at the input.
    tick();
    ready_out = 1'b0;
    op(32'h09000000, res, neg, lat);
    check("bp_first_data", {32'h0, res}, 64'h03000000);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1;
      data_in  = 32'h04000000;
      tick();
      if (!(valid_out && data_out == 32'h03000000 && !ready_in)) ok = 1'b0;
    end
    check("bp_hold_stable", {63'h0, ok}, 64'h1);
    ready_out = 1'b1;
    tick();
    check("bp_release_valid", {63'h0, valid_out}, 64'h0);
    check("bp_release_ready", {63'h0, ready_in}, 64'h1);
    tick();
    valid_in = 1'b0;
    wait_valid(lat);
    check("bp_second_latency", 64'(lat), 64'd28);
    check("bp_second_data", {32'h0, data_out}, 64'h02000000);
    tick();

    // Reset five cycles into a calculation, while the last result is still on the output.
    valid_in = 1'b1;
    data_in  = 32'h10000000;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_data", {32'h0, data_out}, 64'h0);
    check("midrst_valid", {63'h0, valid_out}, 64'h0);
    check("midrst_ready", {63'h0, ready_in}, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    op(32'h09000000, res, neg, lat);
    check("post_rst_data", {32'h0, res}, 64'h03000000);
    check("post_rst_latency", 64'(lat), 64'd28);

    // Short random run with random input gaps and output stalls.
    for (int i = 0; i < 60; i++) begin
      tick();
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[31] = 1'b0;
      ready_out = 1'b0;
      op(x, res, neg, lat);
      check("rand_result", {23'h0, 8'(lat), neg, res}, {23'h0, 8'd28, x[31], model(x)});
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      ready_out = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
